branch_select_ctrl: RTL and testbench
=====================================

# branch_select_ctrl

Sequential next-PC controller that produces the 3-bit selection code consumed by the next-PC select mux. It sits beside the PC register in the single-cycle datapath. Each cycle it picks sequential, branch, jump, return or trap-vector flow from decoded control and event inputs. It also tracks handler entry and exit, saves the exception PC, and halts the core on a double fault.

## Interface
- `VEC_W`, default 16: width of the PC and EPC.
- `clk`, input, 1: system clock; all state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `pc`, input, VEC_W: current PC, captured into EPC on trap entry.
- `pc_next_seq`, input, VEC_W: PC+2, captured into EPC on interrupt entry.
- `stall`, input, 1: freezes the datapath this cycle.
- `is_branch`, input, 1: decoded conditional branch.
- `branch_taken`, input, 1: ALU condition result.
- `is_jump`, input, 1: decoded jump.
- `is_rti`, input, 1: decoded return-from-interrupt.
- `illegal_op`, input, 1: decoder found an illegal opcode.
- `overflow`, input, 1: ALU signed overflow on an arithmetic op.
- `irq`, input, 1: external interrupt request (level).
- `sel`, output, 3: mux selection code (combinational from state and inputs).
- `epc`, output, VEC_W: saved return PC.
- `cause`, output, 2: last trap cause; 0 none, 1 illegal, 2 overflow, 3 irq.
- `in_handler`, output, 1: handler active (interrupts masked).
- `irq_ack`, output, 1: one-cycle pulse when an interrupt is taken.
- `halted`, output, 1: double fault; PC write must be disabled.

## Operation
Selection codes:
- 0: `pc_next_seq`
- 1: branch target
- 2: jump target
- 3: `epc`
- 4: vector 22 (illegal)
- 5: vector 12 (overflow)
- 6: vector 200 (irq)
- 7: never driven

States: RUN, HANDLER, HALT.

Code priority in RUN and HANDLER, highest first:
- `illegal_op` → 4
- `overflow` → 5
- pending irq, RUN only → 6
- `is_rti`, HANDLER only → 3
- `is_jump` → 2
- `is_branch & branch_taken` → 1
- otherwise → 0

Irq pending latch:
- Set on a rising edge of `irq` (registered previous value).
- Cleared when the interrupt is taken.
- Holds while in HANDLER or while stalled.

Transitions, on non-stalled cycles only:
- RUN to HANDLER on code 4, 5 or 6.
- HANDLER to RUN on code 3.
- HANDLER to HALT on code 4 or 5.
- HALT is exited only by `rst`.

Trap entry actions:
- `epc` is loaded with `pc` for codes 4 and 5 (faulting instruction re-executable).
- `epc` is loaded with `pc_next_seq` for code 6.
- `cause` is loaded with the trap cause.
- `irq_ack` pulses for code 6.

`is_rti` in RUN is ignored and produces code 0. While stalled, `sel` still reflects the decision, but no state, EPC, cause or pending update occurs and `irq_ack` stays 0.

## Timing
- `sel` has zero-cycle latency from its inputs.
- State, `epc`, `cause`, `in_handler` and `halted` update one clock after the deciding cycle.
- `irq_ack` is a registered pulse, high during the cycle after the vector-200 selection.
- Reset values: state RUN, `sel`=0, `epc`=0, `cause`=0, `in_handler`=0, `irq_ack`=0, `halted`=0, pending=0, irq-previous=0.
- Reset asserted mid-handler aborts the handler immediately (asynchronously) and discards any pending irq.
- In HALT: `sel`=0 and `halted`=1; every event input is ignored.
- An irq edge arriving in the same cycle as an `is_rti` is latched. It is taken on the first RUN cycle afterwards, so back-to-back handler entry is legal.

## Configuration
- `BRSEL_IRQ_EN` defined: external interrupt path compiled in (pending latch, code 6, `irq_ack`, cause 3).
- `BRSEL_IRQ_EN` undefined:
  - `irq` is unused and `irq_ack` is tied 0.
  - Code 6 is never produced.
  - Only illegal-op and overflow traps enter HANDLER.

## Test plan
- Reset then a taken branch (`is_branch`=1, `branch_taken`=1) → `sel`=1. Not taken → `sel`=0. State stays RUN, all outputs at reset values.
- `illegal_op` with `pc`=0x0040 → `sel`=4. Next cycle `epc`=0x0040, `cause`=1, `in_handler`=1. A following `is_rti` → `sel`=3, then `in_handler`=0.
- `irq` rising edge with `pc_next_seq`=0x0102, `BRSEL_IRQ_EN` defined → `sel`=6. Next cycle `irq_ack`=1, `epc`=0x0102, `cause`=3. A second irq edge while in HANDLER is taken only after `is_rti`.
- `overflow` while in HANDLER → `sel`=5, then `halted`=1 and `sel`=0 thereafter. `rst` pulse → all outputs return to their reset values.
- `stall`=1 with `illegal_op`=1 → `sel`=4, but no state or `epc` change. Releasing the stall performs trap entry.
- `BRSEL_IRQ_EN` undefined: irq toggling → `sel` never 6, `irq_ack` stays 0.

Source files
------------

// File: rtl/branch_select_ctrl.sv
// Next-PC select controller: picks sequential/branch/jump/return/trap-vector flow and tracks handler state.
// Optional macro BRSEL_IRQ_EN compiles in the external interrupt path (pending latch, vector 200, irq_ack).
module branch_select_ctrl #(
    parameter int VEC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VEC_W-1:0] pc,
    input  logic [VEC_W-1:0] pc_next_seq,
    input  logic             stall,
    input  logic             is_branch,
    input  logic             branch_taken,
    input  logic             is_jump,
    input  logic             is_rti,
    input  logic             illegal_op,
    input  logic             overflow,
    input  logic             irq,
    output logic [2:0]       sel,
    output logic [VEC_W-1:0] epc,
    output logic [1:0]       cause,
    output logic             in_handler,
    output logic             irq_ack,
    output logic             halted
);

    localparam logic [2:0] SEL_SEQ = 3'd0;
    localparam logic [2:0] SEL_BR  = 3'd1;
    localparam logic [2:0] SEL_JMP = 3'd2;
    localparam logic [2:0] SEL_EPC = 3'd3;
    localparam logic [2:0] SEL_ILL = 3'd4;
    localparam logic [2:0] SEL_OVF = 3'd5;
    localparam logic [2:0] SEL_IRQ = 3'd6;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HANDLER = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [VEC_W-1:0] epc_q, epc_d;
    logic [1:0]       cause_q, cause_d;
    logic             irq_pend_eff;
    logic             trap_entry;

`ifdef BRSEL_IRQ_EN
    logic irq_prev_q, irq_prev_d;
    logic pending_q, pending_d;
    logic irq_ack_q, irq_ack_d;

    // A fresh edge counts as pending in the same cycle so vector 200 is chosen without delay.
    assign irq_pend_eff = pending_q | (irq & ~irq_prev_q);

    always_comb begin
        irq_prev_d = irq_prev_q;
        pending_d  = pending_q;
        irq_ack_d  = 1'b0;
        if (!stall && state_q != ST_HALT) begin
            irq_prev_d = irq;
            pending_d  = irq_pend_eff;
            if (state_q == ST_RUN && sel == SEL_IRQ) begin
                pending_d = 1'b0;
                irq_ack_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev_q <= 1'b0;
            pending_q  <= 1'b0;
            irq_ack_q  <= 1'b0;
        end else begin
            irq_prev_q <= irq_prev_d;
            pending_q  <= pending_d;
            irq_ack_q  <= irq_ack_d;
        end
    end

    assign irq_ack = irq_ack_q;
`else
    logic unused_irq;
    assign unused_irq   = irq;
    assign irq_pend_eff = 1'b0;
    assign irq_ack      = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            epc_q   <= '0;
            cause_q <= 2'd0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!stall) begin
            case (state_q)
                ST_RUN: begin
                    if (sel == SEL_ILL || sel == SEL_OVF || sel == SEL_IRQ)
                        state_d = ST_HANDLER;
                end
                ST_HANDLER: begin
                    if (sel == SEL_ILL || sel == SEL_OVF)
                        state_d = ST_HALT;
                    else if (sel == SEL_EPC)
                        state_d = ST_RUN;
                end
                default: state_d = ST_HALT;
            endcase
        end
    end

    // Output logic: priority-encoded selection code
    always_comb begin
        sel = SEL_SEQ;
        if (state_q != ST_HALT) begin
            if (illegal_op)
                sel = SEL_ILL;
            else if (overflow)
                sel = SEL_OVF;
            else if (state_q == ST_RUN && irq_pend_eff)
                sel = SEL_IRQ;
            else if (state_q == ST_HANDLER && is_rti)
                sel = SEL_EPC;
            else if (is_jump)
                sel = SEL_JMP;
            else if (is_branch && branch_taken)
                sel = SEL_BR;
        end
    end

    assign trap_entry = !stall && state_q == ST_RUN &&
                        (sel == SEL_ILL || sel == SEL_OVF || sel == SEL_IRQ);

    // Faults save the faulting PC so the instruction can be retried; interrupts resume after it.
    always_comb begin
        epc_d   = epc_q;
        cause_d = cause_q;
        if (trap_entry) begin
            epc_d = (sel == SEL_IRQ) ? pc_next_seq : pc;
            case (sel)
                SEL_ILL: cause_d = 2'd1;
                SEL_OVF: cause_d = 2'd2;
                default: cause_d = 2'd3;
            endcase
        end
    end

    assign epc        = epc_q;
    assign cause      = cause_q;
    assign in_handler = (state_q == ST_HANDLER);
    assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_branch_select_ctrl.sv
// Self-checking bench for branch_select_ctrl: directed steps then randomized traffic against a behavioural model.
module tb_branch_select_ctrl;

`ifdef BRSEL_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc, pc_next_seq;
    logic        stall, is_branch, branch_taken, is_jump, is_rti;
    logic        illegal_op, overflow, irq;
    logic [2:0]  sel;
    logic [15:0] epc;
    logic [1:0]  cause;
    logic        in_handler, irq_ack, halted;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0 = running, 1 = in handler, 2 = halted
    int          m_mode;
    bit          m_pend, m_prev, m_ack;
    logic [15:0] m_epc;
    logic [1:0]  m_cause;

    always #5 clk = ~clk;

    branch_select_ctrl #(.VEC_W(16)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_next_seq(pc_next_seq), .stall(stall),
        .is_branch(is_branch), .branch_taken(branch_taken), .is_jump(is_jump),
        .is_rti(is_rti), .illegal_op(illegal_op), .overflow(overflow), .irq(irq),
        .sel(sel), .epc(epc), .cause(cause), .in_handler(in_handler),
        .irq_ack(irq_ack), .halted(halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        stall = 0; is_branch = 0; branch_taken = 0; is_jump = 0; is_rti = 0;
        illegal_op = 0; overflow = 0; irq = 0;
        pc = 16'h0000; pc_next_seq = 16'h0002;
    endtask

    task automatic model_reset();
        m_mode = 0; m_pend = 0; m_prev = 0; m_ack = 0; m_epc = '0; m_cause = '0;
    endtask

    function automatic int exp_sel();
        bit pe;
        if (m_mode == 2) return 0;
        pe = m_pend || (IRQ_EN && irq && !m_prev);
        if (illegal_op)                return 4;
        if (overflow)                  return 5;
        if (m_mode == 0 && pe)         return 6;
        if (m_mode == 1 && is_rti)     return 3;
        if (is_jump)                   return 2;
        if (is_branch && branch_taken) return 1;
        return 0;
    endfunction

    task automatic model_update(input int c);
        bit pe;
        m_ack = 0;
        if (!stall && m_mode != 2) begin
            pe     = m_pend || (IRQ_EN && irq && !m_prev);
            m_prev = irq;
            m_pend = pe;
            if (m_mode == 0) begin
                if (c >= 4) begin
                    m_mode  = 1;
                    m_epc   = (c == 6) ? pc_next_seq : pc;
                    m_cause = (c == 4) ? 2'd1 : (c == 5) ? 2'd2 : 2'd3;
                end
                if (c == 6) begin
                    m_pend = 0;
                    m_ack  = 1;
                end
            end else begin
                if (c == 3) m_mode = 0;
                else if (c == 4 || c == 5) m_mode = 2;
            end
        end
    endtask

    task automatic check_regs(input string ph);
        chk({ph, "_in_handler"}, in_handler, m_mode == 1);
        chk({ph, "_halted"}, halted, m_mode == 2);
        chk({ph, "_irq_ack"}, irq_ack, m_ack);
        if (m_mode != 2) begin
            chk({ph, "_epc"}, epc, m_epc);
            chk({ph, "_cause"}, cause, m_cause);
        end
    endtask

    // One transaction: inputs already driven at the falling edge
    task automatic cycle(input string tag);
        int c;
        #1;
        c = exp_sel();
        chk({tag, "_sel"}, sel, c);
        $display("%s: stall=%0d ill=%0d ovf=%0d irq=%0d rti=%0d jmp=%0d br=%0d/%0d sel=%0d mode=%0d",
                 tag, stall, illegal_op, overflow, irq, is_rti, is_jump, is_branch, branch_taken,
                 sel, m_mode);
        @(posedge clk);
        model_update(c);
        #1;
        check_regs(tag);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge
    task automatic do_reset(input string tag);
        clear_inputs();
        #2 rst = 1;
        #1;
        model_reset();
        chk({tag, "_sel"}, sel, 0);
        check_regs(tag);
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 0;
        model_reset();
        @(negedge clk);
        do_reset("reset");
        repeat (2) cycle("idle");

        is_branch = 1; branch_taken = 1; cycle("br_taken");
        branch_taken = 0;                cycle("br_not_taken");
        is_branch = 0; is_jump = 1;      cycle("jump");
        is_jump = 0; is_rti = 1;         cycle("rti_in_run");
        is_rti = 0;

        pc = 16'h0040; illegal_op = 1;   cycle("illegal");
        illegal_op = 0; is_rti = 1;      cycle("rti");
        is_rti = 0;                      cycle("after_rti");

        pc_next_seq = 16'h0102; irq = 1; cycle("irq_edge");
        irq = 0;                         cycle("irq_low");
        irq = 1;                         cycle("irq_in_handler");
        irq = 0; is_rti = 1;             cycle("rti_pending");
        is_rti = 0; pc_next_seq = 16'h0200; cycle("irq_retaken");
        is_rti = 1; irq = 1;             cycle("rti_with_edge");
        is_rti = 0; irq = 0;             cycle("b2b_entry");
        is_rti = 1;                      cycle("rti_exit");
        is_rti = 0;

        do_reset("reset2");
        pc = 16'h0080; illegal_op = 1;   cycle("ill_enter");
        illegal_op = 0; overflow = 1;    cycle("double_fault");
        illegal_op = 1; irq = 1;         cycle("halt_ignore");
        overflow = 0; is_jump = 1;       cycle("halt_jump");
        do_reset("reset_halt");

        pc = 16'h00A0; stall = 1; illegal_op = 1; cycle("stall_ill");
        stall = 0;                       cycle("stall_release");
        illegal_op = 0; irq = 1;         cycle("handler_irq");
        do_reset("reset_mid_handler");
        repeat (2) cycle("post_reset");

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset("rnd_reset");
            stall        = ($urandom_range(0, 5) == 0);
            is_branch    = $urandom_range(0, 1);
            branch_taken = $urandom_range(0, 1);
            is_jump      = ($urandom_range(0, 4) == 0);
            is_rti       = ($urandom_range(0, 2) == 0);
            illegal_op   = ($urandom_range(0, 11) == 0);
            overflow     = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 3) == 0) irq = ~irq;
            pc           = 16'($urandom) & 16'hFFFE;
            pc_next_seq  = pc + 16'd2;
            cycle("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
